// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STALL_BITS = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin selector: first set request at or above ptr, wrapping to index 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);
  int j;

  // Scan from the far end so the closest match to ptr wins the last assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Multi-requester burst arbiter in front of a single FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     wr_en,
  output logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_valid,
  input  logic                     full,
  output logic [STALL_BITS-1:0]    stall_cycles
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t            state_reg, state_next;
  logic [IW-1:0]         owner_reg, owner_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [IW-1:0]         ptr_reg, ptr_next;
  logic [NUM_REQ-1:0]    grant_reg, grant_next;
  logic [STALL_BITS-1:0] stall_reg, stall_next;

  logic [WIDTH-1:0] lane_data [NUM_REQ];
  logic [IW-1:0]    ptr_after, pick_ptr, pick_idx;
  logic             pick_found, accept, burst_last, stall_event;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_data[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  // Once the pointer moves past the owner, the owner is last in search order,
  // so one picker covers "other requester first, else re-grant, else idle".
  assign ptr_after = (owner_reg == IW'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
  assign pick_ptr  = (state_reg == BURST) ? ptr_after : ptr_reg;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      count_reg <= '0;
      ptr_reg   <= '0;
      grant_reg <= '0;
      stall_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      count_reg <= count_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      stall_reg <= stall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    count_next = count_reg;
    ptr_next   = ptr_reg;
    accept     = wr_en & wr_valid;
    burst_last = ~req[owner_reg] | (accept & (count_reg == LAST_BEAT));
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = BURST;
          owner_next = pick_idx;
          count_next = '0;
        end
      end
      BURST: begin
        if (burst_last) begin
          ptr_next   = ptr_after;
          count_next = '0;
          if (pick_found) owner_next = pick_idx;
          else            state_next = IDLE;
        end else if (accept) begin
          count_next = count_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    grant_next = (state_next == BURST) ? (NUM_REQ'(1) << owner_next) : '0;

    // A refused beat already means the FIFO is full; full adds no information.
    stall_event = wr_en & ~wr_valid & (full | ~wr_valid);
    stall_next  = (stall_event && stall_reg != '1) ? stall_reg + 1'b1 : stall_reg;
  end

  always_comb begin
    grant        = grant_reg;
    wr_en        = |(grant_reg & req);
    wr_data      = lane_data[owner_reg];
    ack          = grant_reg & req & {NUM_REQ{wr_valid}};
    stall_cycles = stall_reg;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a burst-level model and per-requester scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N*W-1:0] req_data;
  logic [N-1:0] ack, grant;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         wr_valid, full;
  logic [15:0]  stall_cycles;

  always #5 clock = ~clock;

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .grant        (grant),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .full         (full),
    .stall_cycles (stall_cycles)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int total_acks = 0;
  int total_writes = 0;

  logic [W-1:0] cur_data [N];
  int           seq [N];
  logic [W-1:0] exp_q [N][$];

  // Reference: current owner (-1 when idle), beats taken, round-robin start.
  int m_owner, m_cnt, m_ptr, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic new_word(input int i);
    cur_data[i] = {4'(i), 12'(seq[i])};
    seq[i]++;
    exp_q[i].push_back(cur_data[i]);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_ptr   = 0;
    m_stall = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model, cross the edge.
  task automatic step(input logic [N-1:0] r, input logic v);
    logic [N-1:0] one, e_grant, e_ack, a_now;
    logic e_wren, acc;
    one = 1;
    req = r;
    wr_valid = v;
    full = ~v;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = cur_data[i];
    #1;
    e_grant = (m_owner >= 0) ? (one << m_owner) : '0;
    e_wren  = (m_owner >= 0) && r[m_owner];
    e_ack   = (e_wren && v) ? e_grant : '0;
    chk("grant", 32'(grant), 32'(e_grant));
    chk("wr_en", 32'(wr_en), 32'(e_wren));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    a_now = ack;
    acc = e_wren && v;
    if (e_wren && !v && m_stall < 65535) m_stall++;
    if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
      m_cnt = 0;
    end else if (!r[m_owner] || (acc && m_cnt == MB - 1)) begin
      m_ptr = (m_owner + 1) % N;
      m_owner = pick(r, m_ptr);
      m_cnt = 0;
    end else if (acc) begin
      m_cnt++;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (a_now[i]) new_word(i);
  endtask

  // Assert reset between edges and confirm outputs drop without a clock.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_stall", 32'(stall_cycles), 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clock) begin : monitor
    int idx;
    if (reset === 1'b1) begin
      if (!wr_valid) chk("ack_without_valid", 32'(ack), 32'h0);
      if (wr_en && wr_valid) begin
        chk("grant_onehot", 32'($onehot(grant)), 32'h1);
        idx = -1;
        for (int i = 0; i < N; i++) if (grant[i]) idx = i;
        if (idx >= 0) begin
          if (exp_q[idx].size() == 0) chk("scoreboard_empty", 32'(idx), 32'hFFFF_FFFF);
          else chk($sformatf("data_req%0d", idx), 32'(wr_data), 32'(exp_q[idx].pop_front()));
        end
        total_writes++;
        total_acks += $countones(ack);
      end
    end
  end

  initial begin
    logic [N-1:0] rr;
    int s0, sent;
    reset = 1'b0;
    req = '1;
    wr_valid = 1'b1;
    full = 1'b0;
    req_data = '0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      new_word(i);
    end
    repeat (2) @(posedge clock);
    #1;
    chk("por_grant", 32'(grant), 32'h0);
    chk("por_wr_en", 32'(wr_en), 32'h0);
    chk("por_ack", 32'(ack), 32'h0);
    chk("por_stall", 32'(stall_cycles), 32'h0);
    reset = 1'b1;

    // Single requester: repeated bursts with re-grant and no gap.
    repeat (12) step(4'b0001, 1'b1);

    // All requesting: rotation 0,1,2,3,0.
    do_reset();
    repeat (22) step(4'b1111, 1'b1);

    // Owner 1 stalled mid-burst for five cycles.
    do_reset();
    repeat (3) step(4'b0010, 1'b1);
    s0 = int'(stall_cycles);
    repeat (5) step(4'b0010, 1'b0);
    chk("stall_delta", 32'(int'(stall_cycles) - s0), 32'd5);
    chk("stall_owner", 32'(grant), 32'b0010);
    repeat (3) step(4'b0010, 1'b1);

    // Owner 2 drops after one beat, requester 3 waiting.
    do_reset();
    step(4'b0100, 1'b1);
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b1);
    chk("handoff_grant", 32'(grant), 32'b1000);
    repeat (3) step(4'b1000, 1'b1);

    // Reset mid-burst, then restart arbitration.
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b1);
    do_reset();
    step(4'b0100, 1'b1);
    chk("post_reset_grant", 32'(grant), 32'b0100);

    // Random traffic with level-held requests and a sometimes-full FIFO.
    rr = 4'b0100;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
      step(rr, $urandom_range(0, 3) != 0);
    end
    step('0, 1'b1);
    step('0, 1'b1);

    chk("ack_total_vs_writes", 32'(total_acks), 32'(total_writes));
    sent = 0;
    for (int i = 0; i < N; i++) sent += seq[i] - 1;
    chk("words_sent_vs_writes", 32'(sent), 32'(total_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of write requesters sharing one FIFO write port (legal range 2..8).
REQ-002 Parameter WIDTH, default 16, is the data width and matches the FIFO WIDTH.
REQ-003 Parameter MAX_BURST, default 4, is the maximum number of accepted beats per grant (legal range 1..16).
REQ-004 clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester write request, level-held while the requester has data.
REQ-007 req_data  input  NUM_REQ x WIDTH  per-requester write data, valid when the matching req is high.
REQ-008 ack  output  NUM_REQ  per-requester beat accepted this cycle (combinational).
REQ-009 grant  output  NUM_REQ  one-hot registered current owner, all-zero when idle.
REQ-010 wr_en  output  1  FIFO write enable.
REQ-011 wr_data  output  WIDTH  FIFO write data.
REQ-012 wr_valid  input  1  FIFO accepted the write this cycle.
REQ-013 full  input  1  FIFO full flag, used only for the stall statistic.
REQ-014 stall_cycles  output  16  count of cycles with wr_en=1 and wr_valid=0; saturates at 16'hFFFF.

Function
REQ-015 The state machine has states IDLE and BURST, held in a registered state, owner index, beat count and round-robin pointer.
REQ-016 IDLE: grant=0 and wr_en=0; when any req is high, the next edge selects the first requester with req high, searching from the round-robin pointer upward with wrap, and enters BURST with that owner and count=0.
REQ-017 BURST: wr_en = req[owner], wr_data = req_data[owner], ack[owner] = req[owner] & wr_valid, and every other ack bit is 0.
REQ-018 An accepted beat (wr_en & wr_valid) increments count; a refused beat (FIFO full) leaves count and owner unchanged, and the requester holds its data.
REQ-019 The burst ends at the edge where either req[owner] is low, or a beat is accepted with count = MAX_BURST-1.
REQ-020 At burst end the round-robin pointer becomes owner+1 modulo NUM_REQ.
REQ-021 At burst end, if any other req is high, the next owner is selected in the same edge using the updated pointer (no idle bubble), with count=0; otherwise the block goes to IDLE.
REQ-022 At burst end with no other requester pending and req[owner] still high, the same owner is re-granted for a fresh burst.
REQ-023 A requester whose req is low at the burst-end edge is never selected at that edge.
REQ-024 wr_en is never asserted without exactly one grant bit set, and ack is never asserted without wr_valid.
REQ-025 With every requester continuously requesting, no requester waits more than (NUM_REQ-1) bursts for a grant.
REQ-026 stall_cycles increments in any cycle with wr_en=1 and wr_valid=0, independent of full.

Reset
REQ-027 Reset low asynchronously forces state=IDLE, grant=0, owner=0, count=0, pointer=0 and stall_cycles=0; consequently wr_en=0 and ack=0 immediately.
REQ-028 A reset asserted mid-burst discards the burst with no partial-state retention, and arbitration restarts from requester 0 after release.
REQ-029 Reset release is synchronised externally; the first arbitration occurs at the first rising edge after release.

Structure
REQ-030 A shared package fifo_arb_pkg holds the state enum (IDLE, BURST) and the stall counter width constant STALL_BITS=16.
REQ-031 The round-robin selection is a separate combinational sub-module rr_pick (inputs: request vector and pointer; outputs: index and found).
REQ-032 The FIFO itself is instantiated outside this block; this block connects only to the FIFO's wr_en, wr_data, wr_valid and full.

Verification
REQ-033 Scenario 1: req=4'b0001 held, FIFO never full -> grant=0001 one cycle later; ack is high 4 consecutive cycles; at the burst-end edge req0 is re-granted (REQ-022) and writes continue.
REQ-034 Scenario 2: req=4'b1111 held, MAX_BURST=4, FIFO never full -> owners 0,1,2,3,0 in order, each accepting exactly 4 beats with no bubble between bursts.
REQ-035 Scenario 3: owner 1 mid-burst with count=2 and wr_valid forced 0 for 5 cycles -> count stays 2, ack=0, stall_cycles increases by 5, and the owner is unchanged.
REQ-036 Scenario 4: owner 2 drops req after 1 accepted beat while req3 is high -> grant moves to 0b1000 at the next edge and the pointer becomes 3.
REQ-037 Scenario 5: reset asserted low mid-burst between clock edges -> grant, wr_en and ack go to 0 without waiting for a clock edge; after release with req=4'b0100, requester 2 is granted.
REQ-038 All scenarios run with a scoreboard against the real FIFO, checking write order per requester and that the total of acks equals the total of FIFO writes.
